// File: rtl/voice_alloc.sv
// Note-on/note-off voice allocator that manages NUM_VOICES envelope voices.
// Define VOICE_STEAL_EN to steal the oldest busy voice instead of dropping a note-on.
module voice_alloc #(
  parameter int NUM_VOICES = 8,
  parameter int KEY_BITS   = 7,
  parameter int AGE_BITS   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           on_valid,
  output logic                           on_ready,
  input  logic [KEY_BITS-1:0]            on_key,
  input  logic [31:0]                    on_velocity,
  input  logic                           off_valid,
  input  logic [KEY_BITS-1:0]            off_key,
  input  logic [NUM_VOICES-1:0]          voice_avail,
  output logic [NUM_VOICES-1:0]          voice_gate,
  output logic [NUM_VOICES*KEY_BITS-1:0] voice_key,
  output logic [NUM_VOICES*32-1:0]       voice_velocity,
  output logic                           note_drop,
  output logic [1:0]                     alloc_state
);
  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam logic [AGE_BITS-1:0] AGE_MAX = {AGE_BITS{1'b1}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ALLOC = 2'd1, S_STEAL = 2'd2} alloc_t;
  typedef enum logic [1:0] {V_FREE = 2'd0, V_HELD = 2'd1, V_REL = 2'd2} voice_t;

  alloc_t              state_q, state_d;
  logic [IDX_W-1:0]    victim_q, victim_d;
  logic                drop_q, drop_d;
  logic                pend_off_q, pend_off_d;
  logic [KEY_BITS-1:0] pend_key_q;
  logic [31:0]         pend_vel_q;

  voice_t              vstate_q [NUM_VOICES];
  logic [KEY_BITS-1:0] key_q    [NUM_VOICES];
  logic [31:0]         vel_q    [NUM_VOICES];
  logic [AGE_BITS-1:0] age_q    [NUM_VOICES];

  logic [NUM_VOICES-1:0] off_hit;
  logic                  retrig_found, free_found, commit;
  logic [IDX_W-1:0]      retrig_idx, free_idx, commit_idx;

  // Note-on transfers on a clock edge where on_valid and on_ready are both high;
  // on_valid may be held while on_ready is low and the payload must stay stable.
  assign on_ready    = (state_q == S_IDLE) || !rst;
  assign note_drop   = drop_q && rst;
  assign alloc_state = state_q;

  always_comb begin
    off_hit = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      off_hit[i] = off_valid && (vstate_q[i] == V_HELD) && (key_q[i] == off_key);
  end

  // Descending scan so the lowest matching index wins.
  always_comb begin
    retrig_found = 1'b0;
    retrig_idx   = '0;
    free_found   = 1'b0;
    free_idx     = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if ((vstate_q[i] == V_HELD) && !off_hit[i] && (key_q[i] == pend_key_q)) begin
        retrig_found = 1'b1;
        retrig_idx   = IDX_W'(i);
      end
      if (vstate_q[i] == V_FREE) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

`ifdef VOICE_STEAL_EN
  logic                rel_found, held_found;
  logic [AGE_BITS-1:0] rel_age, held_age;
  logic [IDX_W-1:0]    rel_idx, held_idx, steal_idx;

  // Oldest releasing voice first, then oldest held; strict compare keeps ties on the lowest index.
  always_comb begin
    rel_found  = 1'b0;
    held_found = 1'b0;
    rel_age    = '0;
    held_age   = '0;
    rel_idx    = '0;
    held_idx   = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if ((vstate_q[i] == V_REL) || off_hit[i]) begin
        if (!rel_found || (age_q[i] > rel_age)) begin
          rel_found = 1'b1;
          rel_age   = age_q[i];
          rel_idx   = IDX_W'(i);
        end
      end else if (vstate_q[i] == V_HELD) begin
        if (!held_found || (age_q[i] > held_age)) begin
          held_found = 1'b1;
          held_age   = age_q[i];
          held_idx   = IDX_W'(i);
        end
      end
    end
    steal_idx = rel_found ? rel_idx : held_idx;
  end
`endif

  always_comb begin
    state_d    = state_q;
    victim_d   = victim_q;
    drop_d     = 1'b0;
    pend_off_d = 1'b0;
    commit     = 1'b0;
    commit_idx = victim_q;
    case (state_q)
      S_IDLE: begin
        if (on_valid) state_d = S_ALLOC;
      end
      S_ALLOC: begin
        if (retrig_found) begin
          victim_d = retrig_idx;
          state_d  = S_STEAL;
        end else if (free_found) begin
          commit     = 1'b1;
          commit_idx = free_idx;
          state_d    = S_IDLE;
        end else begin
`ifdef VOICE_STEAL_EN
          victim_d = steal_idx;
          state_d  = S_STEAL;
`else
          drop_d   = 1'b1;
          state_d  = S_IDLE;
`endif
        end
      end
      S_STEAL: begin
        commit     = 1'b1;
        commit_idx = victim_q;
        pend_off_d = off_valid && (off_key == pend_key_q);
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      victim_q   <= '0;
      drop_q     <= 1'b0;
      pend_off_q <= 1'b0;
      pend_key_q <= '0;
      pend_vel_q <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        vstate_q[i] <= V_FREE;
        key_q[i]    <= '0;
        vel_q[i]    <= '0;
        age_q[i]    <= '0;
      end
    end else begin
      state_q    <= state_d;
      victim_q   <= victim_d;
      drop_q     <= drop_d;
      pend_off_q <= pend_off_d;
      if ((state_q == S_IDLE) && on_valid) begin
        pend_key_q <= on_key;
        pend_vel_q <= on_velocity;
      end
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (commit && (commit_idx == IDX_W'(i))) begin
          vstate_q[i] <= V_HELD;
          key_q[i]    <= pend_key_q;
          vel_q[i]    <= pend_vel_q;
          age_q[i]    <= '0;
        end else begin
          if (commit && (vstate_q[i] != V_FREE) && (age_q[i] != AGE_MAX))
            age_q[i] <= age_q[i] + 1'b1;
          // A note-off seen while its own note was being stolen in releases it one cycle late.
          if (pend_off_q && (victim_q == IDX_W'(i)) && (vstate_q[i] == V_HELD))
            vstate_q[i] <= V_REL;
          else if (off_hit[i])
            vstate_q[i] <= V_REL;
          else if (voice_avail[i] && (vstate_q[i] == V_REL))
            vstate_q[i] <= V_FREE;
        end
      end
    end
  end

  always_comb begin
    voice_gate     = '0;
    voice_key      = '0;
    voice_velocity = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_gate[i] = rst && (vstate_q[i] == V_HELD) &&
                      !((state_q == S_STEAL) && (victim_q == IDX_W'(i)));
      voice_key[i*KEY_BITS +: KEY_BITS] = key_q[i];
      voice_velocity[i*32 +: 32]        = vel_q[i];
    end
  end

endmodule

// File: tb/tb_voice_alloc.sv
// Bench for voice_alloc: directed scenarios with literal expectations plus randomized
// traffic checked every cycle against a voice-table model.
module tb_voice_alloc;
  localparam int NV = 8;
  localparam int KB = 7;
  localparam int AB = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            on_valid = 1'b0;
  logic            on_ready;
  logic [KB-1:0]   on_key = '0;
  logic [31:0]     on_velocity = '0;
  logic            off_valid = 1'b0;
  logic [KB-1:0]   off_key = '0;
  logic [NV-1:0]   voice_avail = '0;
  logic [NV-1:0]   voice_gate;
  logic [NV*KB-1:0] voice_key;
  logic [NV*32-1:0] voice_velocity;
  logic            note_drop;
  logic [1:0]      alloc_state;

  voice_alloc #(.NUM_VOICES(NV), .KEY_BITS(KB), .AGE_BITS(AB)) dut (
    .clk(clk), .rst(rst),
    .on_valid(on_valid), .on_ready(on_ready), .on_key(on_key), .on_velocity(on_velocity),
    .off_valid(off_valid), .off_key(off_key), .voice_avail(voice_avail),
    .voice_gate(voice_gate), .voice_key(voice_key), .voice_velocity(voice_velocity),
    .note_drop(note_drop), .alloc_state(alloc_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // model: voice table indexed by voice, 0=free 1=held 2=releasing
  int            m_st  [NV];
  logic [KB-1:0] m_key [NV];
  logic [31:0]   m_vel [NV];
  int            m_age [NV];
  int            m_phase;     // cycles into a pending note-on: 0 none, 1 choosing, 2 gap
  int            m_victim;
  bit            m_pend_off;
  bit            m_drop;
  logic [KB-1:0] p_key;
  logic [31:0]   p_vel;

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_st[i] = 0; m_key[i] = '0; m_vel[i] = '0; m_age[i] = 0;
    end
    m_phase = 0; m_victim = 0; m_pend_off = 0; m_drop = 0; p_key = '0; p_vel = '0;
  endtask

  function automatic int oldest(input int st[NV], input bit hit[NV], input int want_rel);
    int best;
    best = -1;
    for (int i = 0; i < NV; i++) begin
      if ((want_rel != 0) ? (st[i] == 2 || hit[i]) : (st[i] == 1 && !hit[i]))
        if (best < 0 || m_age[i] > m_age[best]) best = i;
    end
    return best;
  endfunction

  task automatic model_step();
    int old_st [NV];
    bit hit [NV];
    int nphase, cidx, r, f, s;
    bit commit, npo, ndrop;
    for (int i = 0; i < NV; i++) begin
      old_st[i] = m_st[i];
      hit[i] = off_valid && (m_st[i] == 1) && (m_key[i] == off_key);
    end
    commit = 0; cidx = -1; nphase = m_phase; npo = 0; ndrop = 0; r = -1; f = -1; s = -1;
    if (m_phase == 0) begin
      if (on_valid) begin p_key = on_key; p_vel = on_velocity; nphase = 1; end
    end else if (m_phase == 1) begin
      for (int i = 0; i < NV; i++) begin
        if (r < 0 && old_st[i] == 1 && !hit[i] && m_key[i] == p_key) r = i;
        if (f < 0 && old_st[i] == 0) f = i;
      end
      if (r >= 0) begin m_victim = r; nphase = 2; end
      else if (f >= 0) begin commit = 1; cidx = f; nphase = 0; end
      else begin
`ifdef VOICE_STEAL_EN
        s = oldest(old_st, hit, 1);
        if (s < 0) s = oldest(old_st, hit, 0);
        m_victim = s; nphase = 2;
`else
        ndrop = 1; nphase = 0;
`endif
      end
    end else begin
      commit = 1; cidx = m_victim; nphase = 0;
      npo = off_valid && (off_key == p_key);
    end
    for (int i = 0; i < NV; i++) begin
      if (commit && i == cidx) begin
        m_st[i] = 1; m_key[i] = p_key; m_vel[i] = p_vel; m_age[i] = 0;
      end else begin
        if (commit && old_st[i] != 0 && m_age[i] < (1 << AB) - 1) m_age[i]++;
        if (m_pend_off && i == m_victim && old_st[i] == 1) m_st[i] = 2;
        else if (hit[i]) m_st[i] = 2;
        else if (voice_avail[i] && old_st[i] == 2) m_st[i] = 0;
      end
    end
    m_phase = nphase; m_pend_off = npo; m_drop = ndrop;
  endtask

  always @(posedge clk) begin
    if (!rst) model_reset();
    else model_step();
  end

  // scoreboard compare, one pass per cycle on the falling edge
  logic [NV-1:0]    e_gate;
  logic [NV*KB-1:0] e_key;
  logic [NV*32-1:0] e_vel;
  logic             e_ready;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NV; i++) begin
        e_gate[i] = rst && (m_st[i] == 1) && !(m_phase == 2 && m_victim == i);
        e_key[i*KB +: KB] = m_key[i];
        e_vel[i*32 +: 32] = m_vel[i];
      end
      e_ready = (m_phase == 0) || !rst;
      check("m_ready", 256'(on_ready), 256'(e_ready));
      check("m_idle", 256'((alloc_state == 2'd0) || !rst), 256'(e_ready));
      check("m_gate", 256'(voice_gate), 256'(e_gate));
      check("m_key", 256'(voice_key), 256'(e_key));
      check("m_vel", 256'(voice_velocity), 256'(e_vel));
      check("m_drop", 256'(note_drop), 256'(m_drop && rst));
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic hs_on(input logic [KB-1:0] k, input logic [31:0] v);
    on_valid = 1'b1; on_key = k; on_velocity = v;
    tick();
    on_valid = 1'b0;
  endtask

  task automatic note_off(input logic [KB-1:0] k);
    off_valid = 1'b1; off_key = k;
    tick();
    off_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    tick();
    chk_en = 1'b1;
    at_neg();
    check("rst_ready", 256'(on_ready), 256'(1));
    check("rst_gate", 256'(voice_gate), 256'(0));
    check("rst_key", 256'(voice_key), 256'(0));
    check("rst_vel", 256'(voice_velocity), 256'(0));
    check("rst_drop", 256'(note_drop), 256'(0));
    tick();
    rst = 1'b1;
    tick();

    // first note lands on voice 0
    hs_on(7'd60, 32'h8000_4000);
    at_neg();
    check("t1_ready", 256'(on_ready), 256'(0));
    check("t1_gate", 256'(voice_gate), 256'(0));
    tick(); at_neg();
    check("t2_gate", 256'(voice_gate), 256'(8'h01));
    check("t2_key0", 256'(voice_key[KB-1:0]), 256'(60));
    check("t2_vel0", 256'(voice_velocity[31:0]), 256'(32'h8000_4000));
    check("t2_ready", 256'(on_ready), 256'(1));

    // release and reuse voice 1
    hs_on(7'd62, 32'h0001_0002); tick();
    hs_on(7'd64, 32'h0003_0004); tick(); tick();
    note_off(7'd62);
    at_neg();
    check("off_gate", 256'(voice_gate), 256'(8'h05));
    voice_avail = 8'h02; tick(); voice_avail = '0;
    hs_on(7'd65, 32'h0005_0006); tick(); at_neg();
    check("reuse_gate", 256'(voice_gate), 256'(8'h07));
    check("reuse_key1", 256'(voice_key[2*KB-1:KB]), 256'(65));

    // retrigger key 60 on voice 0
    hs_on(7'd60, 32'h1234_5678); tick(); at_neg();
    check("retrig_low", 256'(voice_gate), 256'(8'h06));
    tick(); at_neg();
    check("retrig_high", 256'(voice_gate), 256'(8'h07));
    check("retrig_vel0", 256'(voice_velocity[31:0]), 256'(32'h1234_5678));
    check("retrig_vel1", 256'(voice_velocity[63:32]), 256'(32'h0005_0006));

    // note-off for the pending key during the gap cycle
    hs_on(7'd64, 32'hAAAA_BBBB); tick();
    off_valid = 1'b1; off_key = 7'd64;
    tick();
    off_valid = 1'b0;
    at_neg();
    check("late_off_t3", 256'(voice_gate), 256'(8'h07));
    tick(); at_neg();
    check("late_off_t4", 256'(voice_gate), 256'(8'h03));

    // same-cycle note-off 60 and note-on 67
    do_reset();
    hs_on(7'd60, 32'h0000_0001); tick(); tick();
    on_valid = 1'b1; on_key = 7'd67; on_velocity = 32'h0000_0002;
    off_valid = 1'b1; off_key = 7'd60;
    tick();
    on_valid = 1'b0; off_valid = 1'b0;
    tick(); at_neg();
    check("same_gate", 256'(voice_gate), 256'(8'h02));
    check("same_key1", 256'(voice_key[2*KB-1:KB]), 256'(67));

    // all voices busy, ninth note
    do_reset();
    for (int k = 0; k < NV; k++) begin
      hs_on(7'(40 + k), 32'(k)); tick();
    end
    hs_on(7'd50, 32'hDEAD_BEEF); tick(); at_neg();
`ifdef VOICE_STEAL_EN
    check("steal_low", 256'(voice_gate), 256'(8'hFE));
    check("steal_drop", 256'(note_drop), 256'(0));
    tick(); at_neg();
    check("steal_high", 256'(voice_gate), 256'(8'hFF));
    check("steal_key0", 256'(voice_key[KB-1:0]), 256'(50));
`else
    check("drop_pulse", 256'(note_drop), 256'(1));
    check("drop_gate", 256'(voice_gate), 256'(8'hFF));
    tick(); at_neg();
    check("drop_clear", 256'(note_drop), 256'(0));
    check("drop_key0", 256'(voice_key[KB-1:0]), 256'(40));
`endif

    // reset in the retrigger gap cycle
    hs_on(7'd43, 32'h0000_0043); tick();
    rst = 1'b0;
    at_neg();
    check("rst_gap_gate", 256'(voice_gate), 256'(0));
    check("rst_gap_ready", 256'(on_ready), 256'(1));
    check("rst_gap_drop", 256'(note_drop), 256'(0));
    tick();
    rst = 1'b1;
    at_neg();
    check("rst_after_gate", 256'(voice_gate), 256'(0));
    check("rst_after_ready", 256'(on_ready), 256'(1));
    check("rst_after_key", 256'(voice_key), 256'(0));
    tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      on_valid    = ($urandom_range(0, 2) == 0);
      on_key      = 7'(60 + $urandom_range(0, 9));
      on_velocity = $urandom();
      off_valid   = ($urandom_range(0, 3) == 0);
      off_key     = 7'(60 + $urandom_range(0, 9));
      for (int v = 0; v < NV; v++) voice_avail[v] = ($urandom_range(0, 5) == 0);
      rst         = ($urandom_range(0, 399) != 0);
      tick();
    end

    on_valid = 1'b0; off_valid = 1'b0; voice_avail = '0; rst = 1'b1;
    tick(); tick(); tick();
    at_neg();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
